pe_config_loader: RTL and testbench
===================================

# pe_config_loader

Configuration writer for the PE array. Accepts a 4-bit nibble stream from chip pins over a valid/ready handshake, packs pairs of nibbles into 8-bit PE control words, and writes them into each PE's control register in index order via one-hot load strobes. When every PE is loaded, it releases the array into run mode.

## Interface
- `NUM_PE`, default 4: number of PEs loaded per frame; must be ≥ 2.
- `IDX_W`, default `$clog2(NUM_PE)`: width of the PE index; derived, do not override.
- `clock` in 1: single clock for the block and array.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `cfg_start` in 1: single-cycle pulse that begins or restarts a configuration frame.
- `cfg_valid` in 1: `cfg_data` holds a valid nibble.
- `cfg_data` in 4: nibble, high nibble of each word first.
- `cfg_ready` out 1: loader accepts a nibble this cycle.
- `ctrl_signals_out` out 8: control-word bus shared by all PEs.
- `pe_cfg_en` out NUM_PE: one-hot control-register load strobe; bit i targets PE i.
- `pe_run_en` out 1: global compute enable for the PE array.
- `cfg_done` out 1: high while in RUN.

## Operation
- States are IDLE, LOAD_HI, LOAD_LO, WRITE, RUN.
- **Handshake:** a nibble transfers on a rising edge where `cfg_valid && cfg_ready`. `cfg_ready = (state==LOAD_HI || state==LOAD_LO) && !cfg_start`.
- **IDLE:** `cfg_start` moves to LOAD_HI and sets idx=0. Otherwise stay.
- **LOAD_HI:** a transfer latches `cfg_data` into word[7:4] and moves to LOAD_LO.
- **LOAD_LO:** a transfer latches word[3:0] and moves to WRITE.
- **WRITE:**
  - `ctrl_signals_out` = word and `pe_cfg_en` = 1<<idx for exactly one cycle.
  - If idx==NUM_PE-1, go to RUN. Otherwise idx+=1 and go to LOAD_HI.
- **RUN:** `pe_run_en`=1 and `cfg_done`=1. `pe_cfg_en`=0. `ctrl_signals_out` holds the last word written.
- **`cfg_start` in any non-IDLE state:**
  - Next state is LOAD_HI with idx=0.
  - Any partial word is discarded.
  - `pe_run_en` drops the following cycle.
  - A WRITE strobe already being driven in the current cycle still completes; the PE register is written.
- **`cfg_valid` without ready:** stalls the frame indefinitely. No timeout.
- **Reset values:** state=IDLE, idx=0, word=8'h00, `cfg_ready`=0, `ctrl_signals_out`=8'h00, `pe_cfg_en`=0, `pe_run_en`=0, `cfg_done`=0.
- **Reset mid-frame:** returns to reset values on the next edge. Already-written PE registers are not cleared by this block.

## Timing
- `cfg_ready`, `pe_cfg_en`, `pe_run_en`, `cfg_done` and `ctrl_signals_out` are decoded from registered state, idx and word. The only combinational input path is `cfg_start`→`cfg_ready`.
- **Per-word latency:** edge accepting the low nibble → WRITE cycle → strobe, captured by PE i at the end of that cycle.
- **Minimum frame:** 3·NUM_PE cycles after the cycle in which `cfg_start` is sampled (12 cycles for NUM_PE=4).
- `cfg_ready` is 0 during WRITE, giving a one-cycle bubble per word.
- `pe_run_en` rises the cycle after the final WRITE.

## Structure
- Shared package `pe_cfg_pkg` holds:
  - `CTRL_W`=8 and `NIB_W`=4;
  - the state enum `cfg_state_t`;
  - field offsets of the control word: alu_op[1:0], sel_op_1[4:2], sel_op_0[7:5].
- State, idx and word use the existing library `register` module with `clear` tied low.
- No new sub-module. One always_ff for next-state/idx/word and one always_comb for outputs.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with random inputs → all outputs 0, state IDLE.
- **Full load, NUM_PE=4:** `cfg_start`, then nibbles 1,2,3,4,5,6,7,8 with `cfg_valid` held high.
  - `pe_cfg_en` 0001/0010/0100/1000 with `ctrl_signals_out` 8'h12/8'h34/8'h56/8'h78.
  - `pe_run_en` high 13 cycles after `cfg_start`.
- **Backpressure and gaps:** randomly deassert `cfg_valid` → same write sequence and values. No nibble dropped or duplicated.
- **Restart mid-frame:** `cfg_start` after 3 nibbles, then a full frame of A,B,…
  - The first write is PE0 = 8'hAB.
  - The partial data never appears on any strobe.
- **Restart from RUN:** `cfg_start` while `cfg_done`=1 → `pe_run_en`/`cfg_done` drop the next cycle and a new frame loads correctly.
- **Simultaneous `cfg_start` and `cfg_valid` in LOAD_LO:** nibble not accepted (`cfg_ready`=0), idx resets to 0, no strobe issued.

Source files
------------

// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE configuration loader: widths, FSM states
// and the bit layout of a PE control word.
package pe_cfg_pkg;

  localparam int CTRL_W = 8;
  localparam int NIB_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    RUN     = 3'd4
  } cfg_state_t;

  localparam int STATE_W = $bits(cfg_state_t);

  // Control-word field layout as seen by each PE.
  localparam int ALU_OP_LSB   = 0;
  localparam int ALU_OP_W     = 2;
  localparam int SEL_OP_1_LSB = 2;
  localparam int SEL_OP_1_W   = 3;
  localparam int SEL_OP_0_LSB = 5;
  localparam int SEL_OP_0_W   = 3;

  function automatic logic [ALU_OP_W-1:0] ctrl_alu_op(input logic [CTRL_W-1:0] w);
    return w[ALU_OP_LSB +: ALU_OP_W];
  endfunction

  function automatic logic [SEL_OP_1_W-1:0] ctrl_sel_op_1(input logic [CTRL_W-1:0] w);
    return w[SEL_OP_1_LSB +: SEL_OP_1_W];
  endfunction

  function automatic logic [SEL_OP_0_W-1:0] ctrl_sel_op_0(input logic [CTRL_W-1:0] w);
    return w[SEL_OP_0_LSB +: SEL_OP_0_W];
  endfunction

endpackage

// File: rtl/register.sv
// Library register: synchronous active-low reset, synchronous clear,
// otherwise loads d every cycle.
module register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pe_config_loader.sv
// Packs a nibble stream into PE control words and writes them into the PE
// array one PE at a time, then enables the array to run.
module pe_config_loader
  import pe_cfg_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = $clog2(NUM_PE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [3:0]        cfg_data,
  output logic              cfg_ready,
  output logic [7:0]        ctrl_signals_out,
  output logic [NUM_PE-1:0] pe_cfg_en,
  output logic              pe_run_en,
  output logic              cfg_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  cfg_state_t          state;
  cfg_state_t          state_next;
  logic [STATE_W-1:0]  state_q;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic [CTRL_W-1:0]   word;
  logic [CTRL_W-1:0]   word_next;
  logic                in_load;

  assign state   = cfg_state_t'(state_q);
  assign in_load = (state == LOAD_HI) || (state == LOAD_LO);

  register #(.WIDTH(STATE_W), .RESET_VAL(IDLE)) u_state_reg (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .d     (state_next),
    .q     (state_q)
  );

  register #(.WIDTH(IDX_W), .RESET_VAL('0)) u_idx_reg (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .d     (idx_next),
    .q     (idx)
  );

  register #(.WIDTH(CTRL_W), .RESET_VAL(8'h00)) u_word_reg (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .d     (word_next),
    .q     (word)
  );

  // A restart wins over everything; stale nibbles are simply overwritten
  // because both halves are re-latched before the next WRITE.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    word_next  = word;
    if (cfg_start) begin
      state_next = LOAD_HI;
      idx_next   = '0;
    end else begin
      case (state)
        LOAD_HI: begin
          if (cfg_valid) begin
            word_next[CTRL_W-1 -: NIB_W] = cfg_data;
            state_next                   = LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (cfg_valid) begin
            word_next[NIB_W-1:0] = cfg_data;
            state_next           = WRITE;
          end
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state_next = RUN;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = LOAD_HI;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    cfg_ready        = in_load && !cfg_start;
    ctrl_signals_out = word;
    pe_cfg_en        = '0;
    if (state == WRITE) begin
      pe_cfg_en = NUM_PE'(1) << idx;
    end
    pe_run_en = (state == RUN);
    cfg_done  = (state == RUN);
  end

endmodule

// File: tb/tb_pe_config_loader.sv
// Self-checking bench for pe_config_loader: table-driven frames plus
// restart/reset corner sequences, strobes checked against a scoreboard.
module tb_pe_config_loader;

  localparam int NUM_PE = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [3:0]        cfg_data = 4'h0;
  logic              cfg_ready;
  logic [7:0]        ctrl_signals_out;
  logic [NUM_PE-1:0] pe_cfg_en;
  logic              pe_run_en;
  logic              cfg_done;

  typedef struct packed {
    logic [NUM_PE-1:0] en;
    logic [7:0]        word;
  } sb_t;

  typedef struct {
    logic [31:0] words;
    int          gap;
    int          lat;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  exp_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   s_cyc = 0;
  bit   mon_on = 1'b0;
  vec_t vecs[4];

  pe_config_loader #(.NUM_PE(NUM_PE)) dut (
    .clock            (clock),
    .reset            (reset),
    .cfg_start        (cfg_start),
    .cfg_valid        (cfg_valid),
    .cfg_data         (cfg_data),
    .cfg_ready        (cfg_ready),
    .ctrl_signals_out (ctrl_signals_out),
    .pe_cfg_en        (pe_cfg_en),
    .pe_run_en        (pe_run_en),
    .cfg_done         (cfg_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every strobe must match the next expected write, in order.
  always @(negedge clock) begin
    if (mon_on && reset && pe_cfg_en != '0) begin
      if (sb_q.size() == 0) begin
        check("spurious_strobe", 32'(pe_cfg_en), 32'h0);
      end else begin
        exp_e = sb_q.pop_front();
        check("strobe_en", 32'(pe_cfg_en), 32'(exp_e.en));
        check("strobe_word", 32'(ctrl_signals_out), 32'(exp_e.word));
        $display("write pe_cfg_en=%b word=%02h", pe_cfg_en, ctrl_signals_out);
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic start_frame();
    cfg_start = 1'b1;
    @(negedge clock);
    s_cyc = cyc;
    check("ready_during_start", 32'(cfg_ready), 32'h0);
    @(posedge clock); #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] n, input int gap, input bit lo,
                             input int pe, input logic [7:0] w);
    int  tries;
    bit  hs;
    for (int k = 0; k < 3; k++) begin
      if (gap > 0 && int'($urandom_range(99)) < gap) begin
        cfg_valid = 1'b0;
        cfg_data  = 4'($urandom);
        @(posedge clock); #1;
      end
    end
    cfg_valid = 1'b1;
    cfg_data  = n;
    tries = 0;
    hs = 1'b0;
    while (!hs && tries < 20) begin
      @(negedge clock);
      hs = cfg_ready;
      if (hs && lo) sb_q.push_back(sb_t'{en: NUM_PE'(1 << pe), word: w});
      @(posedge clock); #1;
      tries++;
    end
    cfg_valid = 1'b0;
    if (!hs) check("nibble_timeout", 32'h0, 32'h1);
  endtask

  task automatic finish_frame(input logic [7:0] last, input int exp_lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!pe_run_en && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("run_en", 32'(pe_run_en), 32'h1);
    if (exp_lat > 0) check("run_latency", 32'(cyc - s_cyc), 32'(exp_lat));
    check("cfg_done", 32'(cfg_done), 32'h1);
    check("ctrl_hold", 32'(ctrl_signals_out), 32'(last));
    check("run_cfg_en", 32'(pe_cfg_en), 32'h0);
    check("run_ready", 32'(cfg_ready), 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("frame done last=%02h run_en=%0d done=%0d", ctrl_signals_out, pe_run_en, cfg_done);
    @(posedge clock); #1;
  endtask

  task automatic run_frame(input bit do_start, input logic [31:0] words,
                           input int gap, input int lat);
    logic [7:0] w;
    if (do_start) start_frame();
    for (int pe = 0; pe < NUM_PE; pe++) begin
      w = words[31 - 8*pe -: 8];
      send_nibble(w[7:4], gap, 1'b0, pe, w);
      send_nibble(w[3:0], gap, 1'b1, pe, w);
    end
    finish_frame(words[7:0], lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{words: 32'h12345678, gap: 0,  lat: 13};
    vecs[1] = '{words: 32'h9ABCDEF0, gap: 40, lat: 0};
    vecs[2] = '{words: 32'h00FF5AA5, gap: 70, lat: 0};
    vecs[3] = '{words: 32'hC3E71B2D, gap: 0,  lat: 13};

    // Reset with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      cfg_start = 1'($urandom);
      cfg_valid = 1'($urandom);
      cfg_data  = 4'($urandom);
      @(negedge clock);
      check("rst_ready", 32'(cfg_ready), 32'h0);
      check("rst_ctrl", 32'(ctrl_signals_out), 32'h0);
      check("rst_cfg_en", 32'(pe_cfg_en), 32'h0);
      check("rst_run_en", 32'(pe_run_en), 32'h0);
      check("rst_done", 32'(cfg_done), 32'h0);
      $display("reset cycle %0d outputs ready=%0d ctrl=%02h en=%b run=%0d", i,
               cfg_ready, ctrl_signals_out, pe_cfg_en, pe_run_en);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 4'hF;
    @(negedge clock);
    check("idle_ready", 32'(cfg_ready), 32'h0);
    @(posedge clock); #1;
    cfg_valid = 1'b0;
    mon_on = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_frame(1'b1, vecs[v].words, vecs[v].gap, vecs[v].lat);
    end

    // Restart from RUN: run/done drop the cycle after start is sampled.
    cfg_start = 1'b1;
    @(negedge clock);
    check("run_still_high", 32'(pe_run_en), 32'h1);
    @(posedge clock); #1;
    cfg_start = 1'b0;
    @(negedge clock);
    check("run_dropped", 32'(pe_run_en), 32'h0);
    check("done_dropped", 32'(cfg_done), 32'h0);
    @(posedge clock); #1;
    run_frame(1'b0, 32'h13579BDF, 0, 0);

    // Restart after 3 nibbles, with a simultaneous valid nibble in LOAD_LO.
    start_frame();
    send_nibble(4'h1, 0, 1'b0, 0, 8'h12);
    send_nibble(4'h2, 0, 1'b1, 0, 8'h12);
    send_nibble(4'h3, 0, 1'b0, 1, 8'h34);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 4'h9;
    @(negedge clock);
    check("ready_start_lo", 32'(cfg_ready), 32'h0);
    @(posedge clock); #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    run_frame(1'b0, 32'hABCDEF01, 0, 0);

    // Restart asserted during a WRITE cycle: that write still completes.
    start_frame();
    send_nibble(4'h5, 0, 1'b0, 0, 8'h5A);
    send_nibble(4'hA, 0, 1'b1, 0, 8'h5A);
    start_frame();
    run_frame(1'b0, 32'h11223344, 0, 0);

    // Reset in the middle of a frame.
    start_frame();
    send_nibble(4'h7, 0, 1'b0, 0, 8'h70);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    cfg_valid = 1'b1;
    cfg_data = 4'h6;
    @(negedge clock);
    check("midrst_ready", 32'(cfg_ready), 32'h0);
    check("midrst_ctrl", 32'(ctrl_signals_out), 32'h0);
    check("midrst_cfg_en", 32'(pe_cfg_en), 32'h0);
    check("midrst_run_en", 32'(pe_run_en), 32'h0);
    check("midrst_done", 32'(cfg_done), 32'h0);
    $display("mid-frame reset ready=%0d ctrl=%02h", cfg_ready, ctrl_signals_out);
    @(posedge clock); #1;
    cfg_valid = 1'b0;
    run_frame(1'b1, 32'h0123ABCD, 30, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
